// File: rtl/video_timing_sequencer_pkg.sv
// rtl/video_timing_sequencer_pkg.sv - shared types, default timing constants and line classification
package video_timing_sequencer_pkg;

  localparam int H_W = 12;
  localparam int V_W = 10;

  typedef logic [H_W-1:0] hcnt_t;
  typedef logic [V_W-1:0] vcnt_t;

  typedef enum logic [1:0] {
    STD_PAL   = 2'd0,
    STD_NTSC  = 2'd1,
    STD_SECAM = 2'd2
  } video_standard_e;

  typedef enum logic [1:0] {
    VSYNC       = 2'd0,
    BLANK       = 2'd1,
    ACTIVE_LINE = 2'd2
  } line_type_e;

  localparam hcnt_t DEF_H_TOTAL_625  = 12'd3200;
  localparam hcnt_t DEF_H_TOTAL_525  = 12'd3178;
  localparam vcnt_t DEF_V_TOTAL_625  = 10'd312;
  localparam vcnt_t DEF_V_TOTAL_525  = 10'd262;
  localparam hcnt_t DEF_HSYNC_LEN    = 12'd235;
  localparam hcnt_t DEF_BURST_START  = 12'd280;
  localparam hcnt_t DEF_ACTIVE_START = 12'd525;
  localparam hcnt_t DEF_ACTIVE_LEN   = 12'd2600;
  localparam vcnt_t DEF_VSYNC_LINES  = 10'd3;
  localparam vcnt_t DEF_VBLANK_LINES = 10'd22;

  function automatic line_type_e classify_line(vcnt_t v, vcnt_t vsync_lines, vcnt_t vblank_lines);
    if (v < vsync_lines)
      return VSYNC;
    else if (v < vblank_lines)
      return BLANK;
    else
      return ACTIVE_LINE;
  endfunction

endpackage

// File: rtl/video_timing_sequencer_line_timer.sv
// rtl/video_timing_sequencer_line_timer.sv - horizontal counter with standard-dependent wrap and
// registered horizontal strobes for the line the parent says comes next
module video_line_timer
  import video_timing_sequencer_pkg::*;
#(
  parameter hcnt_t H_TOTAL_625  = DEF_H_TOTAL_625,
  parameter hcnt_t H_TOTAL_525  = DEF_H_TOTAL_525,
  parameter hcnt_t HSYNC_LEN    = DEF_HSYNC_LEN,
  parameter hcnt_t BURST_START  = DEF_BURST_START,
  parameter hcnt_t ACTIVE_START = DEF_ACTIVE_START,
  parameter hcnt_t ACTIVE_LEN   = DEF_ACTIVE_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            start,
  input  video_standard_e std_cur,
  input  video_standard_e std_nxt,
  input  line_type_e      line_type_nxt,
  output logic            wrap,
  output hcnt_t           h_cnt,
  output logic            sync,
  output logic            newline,
  output logic            qam_startburst,
  output logic            secam_enabled,
  output logic            active
);

  function automatic hcnt_t h_total_of(video_standard_e s);
    return (s == STD_NTSC) ? H_TOTAL_525 : H_TOTAL_625;
  endfunction

  hcnt_t h_nxt;
  hcnt_t broad_end;
  hcnt_t active_end;
  logic  is_vsync;

  // Wrap point follows the standard of the frame in progress; the strobes use the
  // standard of the cycle being presented, which differs only on a frame boundary.
  always_comb begin
    wrap       = (h_cnt == h_total_of(std_cur) - 12'd1);
    h_nxt      = h_cnt + 12'd1;
    if (start || wrap)
      h_nxt = '0;
    broad_end  = h_total_of(std_nxt) - HSYNC_LEN;
    active_end = ACTIVE_START + ACTIVE_LEN;
    is_vsync   = (line_type_nxt == VSYNC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt          <= '0;
      sync           <= 1'b0;
      newline        <= 1'b0;
      qam_startburst <= 1'b0;
      secam_enabled  <= 1'b0;
      active         <= 1'b0;
    end else if (step || start) begin
      h_cnt          <= h_nxt;
      sync           <= is_vsync ? (h_nxt < broad_end) : (h_nxt < HSYNC_LEN);
      newline        <= (h_nxt == '0);
      qam_startburst <= !is_vsync && (std_nxt != STD_SECAM) && (h_nxt == BURST_START);
      secam_enabled  <= !is_vsync && (std_nxt == STD_SECAM) && (h_nxt >= BURST_START);
      active         <= (line_type_nxt == ACTIVE_LINE) && (h_nxt >= ACTIVE_START) &&
                        (h_nxt < active_end);
    end else begin
      sync           <= 1'b0;
      newline        <= 1'b0;
      qam_startburst <= 1'b0;
      secam_enabled  <= 1'b0;
      active         <= 1'b0;
    end
  end

endmodule

// File: rtl/video_timing_sequencer.sv
// rtl/video_timing_sequencer.sv - composite video strobe sequencer: owns line count, line type
// and the frame-latched standard; horizontal timing lives in video_line_timer
module video_timing_sequencer
  import video_timing_sequencer_pkg::*;
#(
  parameter hcnt_t H_TOTAL_625  = DEF_H_TOTAL_625,
  parameter hcnt_t H_TOTAL_525  = DEF_H_TOTAL_525,
  parameter vcnt_t V_TOTAL_625  = DEF_V_TOTAL_625,
  parameter vcnt_t V_TOTAL_525  = DEF_V_TOTAL_525,
  parameter hcnt_t HSYNC_LEN    = DEF_HSYNC_LEN,
  parameter hcnt_t BURST_START  = DEF_BURST_START,
  parameter hcnt_t ACTIVE_START = DEF_ACTIVE_START,
  parameter hcnt_t ACTIVE_LEN   = DEF_ACTIVE_LEN,
  parameter vcnt_t VSYNC_LINES  = DEF_VSYNC_LINES,
  parameter vcnt_t VBLANK_LINES = DEF_VBLANK_LINES
) (
  input  logic            clk,
  input  logic            rst,
  input  video_standard_e video_standard,
  input  logic            enable,
  output logic            sync,
  output logic            newframe,
  output logic            newline,
  output logic            qam_startburst,
  output logic            secam_enabled,
  output logic            active,
  output video_standard_e std_cur,
  output hcnt_t           h_cnt,
  output vcnt_t           v_cnt
);

  function automatic vcnt_t v_total_of(video_standard_e s);
    return (s == STD_NTSC) ? V_TOTAL_525 : V_TOTAL_625;
  endfunction

  logic            running;
  logic            start;
  logic            step;
  logic            h_wrap;
  logic            v_last;
  logic            line_end;
  logic            frame_end;
  vcnt_t           v_nxt;
  video_standard_e std_nxt;
  line_type_e      line_type;
  line_type_e      line_type_nxt;

  // The first enabled cycle out of reset presents count (0,0) as a fresh frame
  // instead of advancing past it.
  always_comb begin
    start         = enable && !running;
    step          = enable && running;
    v_last        = (v_cnt == v_total_of(std_cur) - 10'd1);
    line_end      = step && h_wrap;
    frame_end     = line_end && v_last;
    v_nxt         = v_cnt;
    if (start || frame_end)
      v_nxt = '0;
    else if (line_end)
      v_nxt = v_cnt + 10'd1;
    std_nxt       = (start || frame_end) ? video_standard : std_cur;
    line_type_nxt = line_type;
    if (start || line_end)
      line_type_nxt = classify_line(v_nxt, VSYNC_LINES, VBLANK_LINES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running   <= 1'b0;
      v_cnt     <= '0;
      std_cur   <= STD_PAL;
      line_type <= VSYNC;
      newframe  <= 1'b0;
    end else if (start || step) begin
      running   <= 1'b1;
      v_cnt     <= v_nxt;
      std_cur   <= std_nxt;
      line_type <= line_type_nxt;
      newframe  <= start || frame_end;
    end else begin
      newframe  <= 1'b0;
    end
  end

  video_line_timer #(
    .H_TOTAL_625  (H_TOTAL_625),
    .H_TOTAL_525  (H_TOTAL_525),
    .HSYNC_LEN    (HSYNC_LEN),
    .BURST_START  (BURST_START),
    .ACTIVE_START (ACTIVE_START),
    .ACTIVE_LEN   (ACTIVE_LEN)
  ) u_line_timer (
    .clk            (clk),
    .rst            (rst),
    .step           (step),
    .start          (start),
    .std_cur        (std_cur),
    .std_nxt        (std_nxt),
    .line_type_nxt  (line_type_nxt),
    .wrap           (h_wrap),
    .h_cnt          (h_cnt),
    .sync           (sync),
    .newline        (newline),
    .qam_startburst (qam_startburst),
    .secam_enabled  (secam_enabled),
    .active         (active)
  );

endmodule

// File: tb/tb_video_timing_sequencer.sv
// tb/tb_video_timing_sequencer.sv - scoreboard bench: a compact-timing instance and a full-timing instance
module tb_video_timing_sequencer;
  import video_timing_sequencer_pkg::*;

  typedef struct {
    int ht625, ht525, vt625, vt525, hs, bs, as, al, vs, vb;
  } cfg_t;

  typedef struct {
    int sync, newframe, newline, qam, secam, active, std, h, v;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  video_standard_e video_standard;

  logic s_sync, s_newframe, s_newline, s_qam, s_secam, s_active;
  video_standard_e s_std;
  hcnt_t s_h;
  vcnt_t s_v;
  logic d_sync, d_newframe, d_newline, d_qam, d_secam, d_active;
  video_standard_e d_std;
  hcnt_t d_h;
  vcnt_t d_v;

  int checks = 0;
  int errors = 0;
  int hold = 0;

  cfg_t cfg[2];
  int   t_m[2];
  int   s_m[2];
  bit   run_m[2];
  obs_t q_s[$];
  obs_t q_d[$];

  always #5 clk = ~clk;

  video_timing_sequencer #(
    .H_TOTAL_625(12'd64), .H_TOTAL_525(12'd58), .V_TOTAL_625(10'd30), .V_TOTAL_525(10'd26),
    .HSYNC_LEN(12'd5), .BURST_START(12'd8), .ACTIVE_START(12'd12), .ACTIVE_LEN(12'd40),
    .VSYNC_LINES(10'd3), .VBLANK_LINES(10'd6)
  ) dut_s (
    .clk(clk), .rst(rst), .video_standard(video_standard), .enable(enable),
    .sync(s_sync), .newframe(s_newframe), .newline(s_newline), .qam_startburst(s_qam),
    .secam_enabled(s_secam), .active(s_active), .std_cur(s_std), .h_cnt(s_h), .v_cnt(s_v)
  );

  video_timing_sequencer dut_d (
    .clk(clk), .rst(rst), .video_standard(video_standard), .enable(enable),
    .sync(d_sync), .newframe(d_newframe), .newline(d_newline), .qam_startburst(d_qam),
    .secam_enabled(d_secam), .active(d_active), .std_cur(d_std), .h_cnt(d_h), .v_cnt(d_v)
  );

  // Reference: position in the frame is a plain enabled-cycle index t; line and
  // column fall out of division by the line length of the standard in force.
  function automatic obs_t predict(cfg_t c, int s, int t, bit en);
    obs_t o;
    int ht;
    bit vs_line;
    ht = (s == 1) ? c.ht525 : c.ht625;
    o.h = t % ht;
    o.v = t / ht;
    o.std = s;
    vs_line = (o.v < c.vs);
    o.sync     = int'(en && (vs_line ? (o.h < ht - c.hs) : (o.h < c.hs)));
    o.newframe = int'(en && t == 0);
    o.newline  = int'(en && o.h == 0);
    o.qam      = int'(en && !vs_line && s != 2 && o.h == c.bs);
    o.secam    = int'(en && !vs_line && s == 2 && o.h >= c.bs);
    o.active   = int'(en && o.v >= c.vb && o.h >= c.as && o.h < c.as + c.al);
    return o;
  endfunction

  function automatic int frame_len(cfg_t c, int s);
    return (s == 1) ? c.ht525 * c.vt525 : c.ht625 * c.vt625;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_obs(string tag, obs_t a, obs_t e);
    cmp({tag, ".sync"}, a.sync, e.sync);
    cmp({tag, ".newframe"}, a.newframe, e.newframe);
    cmp({tag, ".newline"}, a.newline, e.newline);
    cmp({tag, ".qam_startburst"}, a.qam, e.qam);
    cmp({tag, ".secam_enabled"}, a.secam, e.secam);
    cmp({tag, ".active"}, a.active, e.active);
    cmp({tag, ".std_cur"}, a.std, e.std);
    cmp({tag, ".h_cnt"}, a.h, e.h);
    cmp({tag, ".v_cnt"}, a.v, e.v);
  endtask

  function automatic obs_t sample_s();
    obs_t o;
    o.sync = int'(s_sync); o.newframe = int'(s_newframe); o.newline = int'(s_newline);
    o.qam = int'(s_qam); o.secam = int'(s_secam); o.active = int'(s_active);
    o.std = int'(s_std); o.h = int'(s_h); o.v = int'(s_v);
    return o;
  endfunction

  function automatic obs_t sample_d();
    obs_t o;
    o.sync = int'(d_sync); o.newframe = int'(d_newframe); o.newline = int'(d_newline);
    o.qam = int'(d_qam); o.secam = int'(d_secam); o.active = int'(d_active);
    o.std = int'(d_std); o.h = int'(d_h); o.v = int'(d_v);
    return o;
  endfunction

  // Model update and expectation push on every clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      obs_t o;
      if (rst) begin
        run_m[i] = 1'b0;
        t_m[i] = 0;
        s_m[i] = 0;
        o = predict(cfg[i], 0, 0, 1'b0);
      end else if (enable) begin
        if (!run_m[i]) begin
          run_m[i] = 1'b1;
          t_m[i] = 0;
          s_m[i] = int'(video_standard);
        end else if (t_m[i] == frame_len(cfg[i], s_m[i]) - 1) begin
          t_m[i] = 0;
          s_m[i] = int'(video_standard);
        end else begin
          t_m[i]++;
        end
        o = predict(cfg[i], s_m[i], t_m[i], 1'b1);
      end else begin
        o = predict(cfg[i], s_m[i], t_m[i], 1'b0);
      end
      if (i == 0) q_s.push_back(o);
      else q_d.push_back(o);
    end
  end

  // Monitor: pops one expectation per instance per cycle and compares.
  always @(posedge clk) begin
    #1;
    if (q_s.size() == 0) cmp("small.queue_empty", 1, 0);
    else cmp_obs("small", sample_s(), q_s.pop_front());
    if (q_d.size() == 0) cmp("full.queue_empty", 1, 0);
    else cmp_obs("full", sample_d(), q_d.pop_front());
  end

  task automatic run_random(int n, int forced_drop_at);
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      if (!enable) begin
        if (hold <= 0) enable = 1'b1;
        else hold--;
      end else if ($urandom_range(0, 999) == 0) begin
        enable = 1'b0;
        hold = int'($urandom_range(1, 60));
      end
      if (cyc == forced_drop_at) begin
        enable = 1'b0;
        hold = 49;
      end
      if ($urandom_range(0, 2999) == 0)
        video_standard = video_standard_e'($urandom_range(0, 2));
    end
  endtask

  initial begin
    cfg[0] = '{64, 58, 30, 26, 5, 8, 12, 40, 3, 6};
    cfg[1] = '{3200, 3178, 312, 262, 235, 280, 525, 2600, 3, 22};
    rst = 1'b1;
    enable = 1'b0;
    video_standard = STD_PAL;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    run_random(80000, 30000);

    // Asynchronous reset mid-line: outputs must clear before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp_obs("async_rst.small", sample_s(), predict(cfg[0], 0, 0, 1'b0));
    cmp_obs("async_rst.full", sample_d(), predict(cfg[1], 0, 0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    hold = 0;
    run_random(8000, 3000);

    enable = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
